// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg -- shared constants and types for the instruction-fetch stage.
//
//   ILEN          instruction width in bits
//   NOP           canonical no-op (addi x0,x0,0), shown to decode when the
//                 prefetch buffer is empty
//   FETCH_XLEN    address width of the default fetch_entry_t view
//   fetch_entry_t one prefetch buffer entry {instr, pc} at the default width
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    localparam int FETCH_XLEN = 32;

    typedef struct packed {
        logic [ILEN-1:0]       instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo -- small synchronous FIFO used as the instruction prefetch buffer.
//
// Parameters
//   DEPTH   number of entries; must be a power of two, minimum 2
//   WIDTH   entry width in bits
//
// Ports
//   clk_i      clock, all updates on the rising edge
//   rst_ni     asynchronous active-low reset; empties the FIFO
//   flush      drop every entry; wins over push and pop in the same cycle
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        remove the head entry
//   head       current head entry (undefined content while count == 0)
//   count      number of valid entries, 0..DEPTH
//
// The owner guarantees push is never asserted when full and pop is never
// asserted when empty.
// ---------------------------------------------------------------------------
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array has no reset; count and the pointers define
    // which entries are meaningful, so resetting the data would only cost
    // flops without changing behaviour.
    always_ff @(posedge clk_i) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch -- instruction-fetch stage with a prefetch buffer.
//
// Owns the PC, streams sequential word fetches to a synchronous instruction
// memory with one cycle of read latency, buffers the returned words with
// their PCs, and presents them to decode over a valid/ready handshake.
// A redirect flushes the buffer, discards any in-flight response and
// restarts fetching at the (word-aligned) target.
//
// Parameters
//   XLEN        PC / address width
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  prefetch entries; power of two, minimum 2
//   IMEM_AW     instruction memory word-address width
//
// Ports
//   clk_i             clock
//   rst_ni            asynchronous active-low reset
//   redirect_i        flush and load redirect_pc_i
//   redirect_pc_i     redirect target (bits [1:0] ignored)
//   imem_req_o        fetch request this cycle
//   imem_addr_o       word address, pc_q[IMEM_AW+1:2]
//   imem_rdata_i      instruction word, valid the cycle after a request
//   instr_valid_o     buffer head valid
//   instr_ready_i     decode accepts the head
//   instr_o           head instruction, NOP when empty
//   instr_pc_o        PC of the head instruction, 0 when empty
//
// Optional build macro IFU_PERF_CNT_EN adds:
//   perf_fetch_cnt_o  instructions handed to decode (wrapping)
//   perf_stall_cnt_o  cycles with no valid head and no redirect (wrapping)
// ---------------------------------------------------------------------------
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              IMEM_AW    = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               imem_req_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [ILEN-1:0]    imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [ILEN-1:0]    instr_o,
    output logic [XLEN-1:0]    instr_pc_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic            drop_q;

    entry_t          head;
    entry_t          push_entry;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // Issue: a request is allowed only if the entry it will create still
    // fits, counting what is buffered, what is in flight, and what leaves
    // this cycle. count + inflight >= pop always, so no underflow.
    // ------------------------------------------------------------------
    assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    // rst_ni gates the request so the memory sees no fetch while in reset.
    assign imem_req_o  = rst_ni & ~redirect_i & (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o = pc_q[IMEM_AW+1:2];

    // NOTE: every register below uses non-blocking assignment so all of
    // them sample the pre-edge values of each other, exactly like flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            inflight_q <= imem_req_o;
            // A response still owed for the old stream must not be kept.
            drop_q     <= redirect_i & inflight_q;
            if (redirect_i) begin
                pc_q <= redirect_pc_i & ~XLEN'(3);
            end else if (imem_req_o) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + XLEN'(4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Return path into the prefetch buffer. A redirect flushes the buffer
    // and the flush wins over a same-cycle push or pop inside the FIFO.
    // ------------------------------------------------------------------
    assign push             = inflight_q & ~drop_q;
    assign push_entry.instr = imem_rdata_i;
    assign push_entry.pc    = req_pc_q;

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign instr_valid_o = (count != '0);

    // NOTE: both outputs get their empty-buffer value first, so every path
    // through the block assigns them and no latch is inferred.
    always_comb begin
        instr_o    = NOP;
        instr_pc_o = '0;
        if (instr_valid_o) begin
            instr_o    = head.instr;
            instr_pc_o = head.pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            end
            if (!instr_valid_o && !redirect_i) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch -- self-checking bench for ifu_prefetch.
// Cycle-by-cycle vector table for start-up and back-pressure, hand-written
// sequences for redirects, wrap-around and asynchronous reset, and a PC
// scoreboard that checks every handshake against the expected stream.
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] NOP_EXP = 32'h0000_0013;

    logic        clk_i;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    ifu_prefetch #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4),
        .IMEM_AW    (10)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instruction memory: returns the word address as data, one cycle later.
    always @(posedge clk_i) begin
        if (imem_req_o) begin
            imem_rdata_i <= {22'b0, imem_addr_o};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] base;
        base = pc & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(base + 32'(4 * i));
        end
    endtask

    // Drive one cycle's inputs at the falling edge, sample 1 time unit later.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk_i);
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (rd) sb_restart(rpc);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic req, input logic [9:0] addr,
                                input logic valid, input logic [31:0] pc);
        logic [31:0] exp_instr;
        exp_instr = valid ? {22'b0, pc[11:2]} : NOP_EXP;
        check({tag, ".req"},   imem_req_o,    req);
        check({tag, ".addr"},  imem_addr_o,   addr);
        check({tag, ".valid"}, instr_valid_o, valid);
        check({tag, ".pc"},    instr_pc_o,    valid ? pc : 32'h0);
        check({tag, ".instr"}, instr_o,       exp_instr);
    endtask

    task automatic do_reset();
        rst_ni        = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        expect_cycle("reset", 1'b0, 10'h040, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check("reset.perf_fetch", perf_fetch_cnt_o, 32'h0);
        check("reset.perf_stall", perf_stall_cnt_o, 32'h0);
`endif
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sb_restart(RST_PC);
    endtask

    // Scoreboard: every accepted instruction must be the next expected PC.
    always begin
        @(negedge clk_i);
        #2;
        if (rst_ni === 1'b1 && instr_valid_o === 1'b1 && instr_ready_i === 1'b1 &&
            redirect_i === 1'b0) begin
            check("sb_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc",    instr_pc_o, e);
                check("sb_instr", instr_o,    {22'b0, e[11:2]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        ready;
        logic        req;
        logic [9:0]  addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[22];

    initial begin
        // Start-up stream, then 10 cycles of back-pressure, then drain.
        vecs[0]  = '{1'b1, 1'b1, 10'h040, 1'b0, 32'h000};
        vecs[1]  = '{1'b1, 1'b1, 10'h041, 1'b0, 32'h000};
        vecs[2]  = '{1'b1, 1'b1, 10'h042, 1'b1, 32'h100};
        vecs[3]  = '{1'b1, 1'b1, 10'h043, 1'b1, 32'h104};
        vecs[4]  = '{1'b1, 1'b1, 10'h044, 1'b1, 32'h108};
        vecs[5]  = '{1'b1, 1'b1, 10'h045, 1'b1, 32'h10C};
        vecs[6]  = '{1'b0, 1'b1, 10'h046, 1'b1, 32'h110};
        vecs[7]  = '{1'b0, 1'b1, 10'h047, 1'b1, 32'h110};
        for (int i = 8; i < 16; i++) begin
            vecs[i] = '{1'b0, 1'b0, 10'h048, 1'b1, 32'h110};
        end
        vecs[16] = '{1'b1, 1'b1, 10'h048, 1'b1, 32'h110};
        vecs[17] = '{1'b1, 1'b1, 10'h049, 1'b1, 32'h114};
        vecs[18] = '{1'b1, 1'b1, 10'h04A, 1'b1, 32'h118};
        vecs[19] = '{1'b1, 1'b1, 10'h04B, 1'b1, 32'h11C};
        vecs[20] = '{1'b1, 1'b1, 10'h04C, 1'b1, 32'h120};
        vecs[21] = '{1'b1, 1'b1, 10'h04D, 1'b1, 32'h124};

        // ---- Start-up and back-pressure ----
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].ready, 1'b0, 32'h0);
            expect_cycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                         vecs[i].valid, vecs[i].pc);
        end

        // ---- Redirect while the response for 0x10C is in flight ----
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        expect_cycle("rd_c4", 1'b0, 10'h044, 1'b1, 32'h108);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("rd_c5", 1'b1, 10'h080, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("rd_c6", 1'b1, 10'h081, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("rd_c7", 1'b1, 10'h082, 1'b1, 32'h200);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("rd_c8", 1'b1, 10'h083, 1'b1, 32'h204);

        // ---- Back-to-back redirects, unaligned target, PC wrap ----
        step(1'b1, 1'b1, 32'h500);
        expect_cycle("b2b_c9", 1'b0, 10'h084, 1'b1, 32'h208);
        step(1'b1, 1'b1, 32'hFFFF_FFFA);
        expect_cycle("b2b_c10", 1'b0, 10'h140, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("b2b_c11", 1'b1, 10'h3FE, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("b2b_c12", 1'b1, 10'h3FF, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("b2b_c13", 1'b1, 10'h000, 1'b1, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("b2b_c14", 1'b1, 10'h001, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("b2b_c15", 1'b1, 10'h002, 1'b1, 32'h0000_0000);

        // ---- Asynchronous reset pulse between clock edges ----
        step(1'b1, 1'b0, 32'h0);
        rst_ni = 1'b0;
        #1;
        expect_cycle("arst", 1'b0, 10'h040, 1'b0, 32'h0);
        #1;
        rst_ni = 1'b1;
        sb_restart(RST_PC);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("arst_c1", 1'b1, 10'h041, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("arst_c2", 1'b1, 10'h042, 1'b1, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("arst_c3", 1'b1, 10'h043, 1'b1, 32'h104);

`ifdef IFU_PERF_CNT_EN
        // ---- Performance counters: 20 ready cycles, then a redirect ----
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h300);
        check("perf_c20.fetch", perf_fetch_cnt_o, 32'd18);
        check("perf_c20.stall", perf_stall_cnt_o, 32'd2);
        step(1'b1, 1'b0, 32'h0);
        check("perf_c21.fetch", perf_fetch_cnt_o, 32'd18);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        expect_cycle("perf_c23", 1'b1, 10'h0C2, 1'b1, 32'h300);
        check("perf_c23.fetch", perf_fetch_cnt_o, 32'd18);
        check("perf_c23.stall", perf_stall_cnt_o, 32'd4);
`endif

        step(1'b0, 1'b0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
